im_fetch_scheduler: RTL and testbench

// Streams low-dim item-memory addresses from a shared data-memory read port into item memory ports A and B.
// On start, fetches num_items words per enabled channel from base + i*stride.
// A round-robin arbiter shares the single read port between the two channels.

---
 rtl/im_sched_pkg.sv | 19 +
 rtl/im_fetch_scheduler_fifo.sv | 76 +++++++
 rtl/im_fetch_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_im_fetch_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/im_sched_pkg.sv
// Shared types for the item-memory fetch scheduler: FSM states and channel ids.
package im_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    CH_A = 1'b0,
    CH_B = 1'b1
  } chan_id_t;

  function automatic chan_id_t other_chan(input chan_id_t c);
    return (c == CH_A) ? CH_B : CH_A;
  endfunction

endpackage

// File: rtl/im_fetch_scheduler_fifo.sv
// Small synchronous hold FIFO; push and pop may coincide even when full.
module im_fetch_scheduler_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clr_i,
  input  logic                         push_i,
  input  logic [Width-1:0]             data_i,
  input  logic                         pop_i,
  output logic [Width-1:0]             data_o,
  output logic                         empty_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != CntW'(Depth)) || do_pop);
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CntW'(1);
      end else if (!do_push && do_pop) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/im_fetch_scheduler.sv
// Fetches per-channel item addresses through one shared read port (round-robin)
// and hands them to item-memory ports A/B via small hold FIFOs.
module im_fetch_scheduler
  import im_sched_pkg::*;
#(
  parameter int unsigned MemAddrWidth  = 32,
  parameter int unsigned ImAddrWidth   = 32,
  parameter int unsigned CountWidth    = 16,
  parameter int unsigned ChanFifoDepth = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clr_i,
  input  logic                    start_i,
  input  logic                    port_b_en_i,
  input  logic [CountWidth-1:0]   num_items_i,
  input  logic [MemAddrWidth-1:0] base_a_i,
  input  logic [MemAddrWidth-1:0] base_b_i,
  input  logic [MemAddrWidth-1:0] stride_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    mem_req_o,
  output logic [MemAddrWidth-1:0] mem_addr_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [ImAddrWidth-1:0]  mem_rdata_i,
  output logic [ImAddrWidth-1:0]  im_a_addr_o,
  output logic                    im_a_valid_o,
  input  logic                    im_a_ready_i,
  output logic [ImAddrWidth-1:0]  im_b_addr_o,
  output logic                    im_b_valid_o,
  input  logic                    im_b_ready_i
);

  localparam int unsigned CntW = $clog2(ChanFifoDepth + 1);
  localparam int unsigned OccW = CntW + 1;

  state_t                  state_q, state_d;
  logic [CountWidth-1:0]   num_q, num_d;
  logic [MemAddrWidth-1:0] base_a_q, base_a_d;
  logic [MemAddrWidth-1:0] base_b_q, base_b_d;
  logic [MemAddrWidth-1:0] stride_q, stride_d;
  logic                    b_en_q, b_en_d;
  logic [CountWidth-1:0]   issued_a_q, issued_a_d;
  logic [CountWidth-1:0]   issued_b_q, issued_b_d;
  chan_id_t                rr_q, rr_d;
  chan_id_t                sel_q, sel_d;
  logic                    hold_q, hold_d;
  logic                    tag_vld_q, tag_vld_d;
  chan_id_t                tag_id_q, tag_id_d;

  chan_id_t                sel;
  logic                    tag_a, tag_b;
  logic [OccW-1:0]         occ_a, occ_b;
  logic                    elig_a, elig_b;
  logic                    grant, all_done;
  logic                    push_a, push_b;
  logic                    empty_a, empty_b;
  logic [CntW-1:0]         cnt_a, cnt_b;

  // Outstanding reads count against FIFO space so a response always has a slot.
  always_comb begin
    tag_a  = tag_vld_q && (tag_id_q == CH_A);
    tag_b  = tag_vld_q && (tag_id_q == CH_B);
    occ_a  = OccW'(cnt_a) + OccW'(tag_a);
    occ_b  = OccW'(cnt_b) + OccW'(tag_b);
    elig_a = (state_q == RUN) && (issued_a_q < num_q) && (occ_a < OccW'(ChanFifoDepth));
    elig_b = (state_q == RUN) && b_en_q && (issued_b_q < num_q) &&
             (occ_b < OccW'(ChanFifoDepth));

    // A stalled request keeps its channel until granted.
    sel = CH_A;
    if (hold_q) begin
      sel = sel_q;
    end else if (elig_a && elig_b) begin
      sel = rr_q;
    end else if (elig_b) begin
      sel = CH_B;
    end

    mem_req_o  = (state_q == RUN) && (hold_q || elig_a || elig_b);
    mem_addr_o = (sel == CH_A) ? base_a_q + MemAddrWidth'(issued_a_q) * stride_q
                               : base_b_q + MemAddrWidth'(issued_b_q) * stride_q;
    grant      = mem_req_o && mem_gnt_i;
    push_a     = mem_rvalid_i && tag_a;
    push_b     = mem_rvalid_i && tag_b;
    all_done   = (issued_a_q == num_q) && (!b_en_q || (issued_b_q == num_q)) &&
                 !tag_vld_q && empty_a && empty_b;
  end

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    base_a_d   = base_a_q;
    base_b_d   = base_b_q;
    stride_d   = stride_q;
    b_en_d     = b_en_q;
    issued_a_d = issued_a_q;
    issued_b_d = issued_b_q;
    rr_d       = rr_q;
    sel_d      = sel;
    hold_d     = mem_req_o && !mem_gnt_i;
    tag_vld_d  = grant;
    tag_id_d   = grant ? sel : tag_id_q;

    if (grant) begin
      rr_d = other_chan(sel);
      if (sel == CH_A) begin
        issued_a_d = issued_a_q + CountWidth'(1);
      end else begin
        issued_b_d = issued_b_q + CountWidth'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          num_d      = num_items_i;
          base_a_d   = base_a_i;
          base_b_d   = base_b_i;
          stride_d   = stride_i;
          b_en_d     = port_b_en_i;
          issued_a_d = '0;
          issued_b_d = '0;
          state_d    = (num_items_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (all_done) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (clr_i) begin
      state_d    = IDLE;
      issued_a_d = '0;
      issued_b_d = '0;
      tag_vld_d  = 1'b0;
      hold_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      num_q      <= '0;
      base_a_q   <= '0;
      base_b_q   <= '0;
      stride_q   <= '0;
      b_en_q     <= 1'b0;
      issued_a_q <= '0;
      issued_b_q <= '0;
      rr_q       <= CH_A;
      sel_q      <= CH_A;
      hold_q     <= 1'b0;
      tag_vld_q  <= 1'b0;
      tag_id_q   <= CH_A;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      base_a_q   <= base_a_d;
      base_b_q   <= base_b_d;
      stride_q   <= stride_d;
      b_en_q     <= b_en_d;
      issued_a_q <= issued_a_d;
      issued_b_q <= issued_b_d;
      rr_q       <= rr_d;
      sel_q      <= sel_d;
      hold_q     <= hold_d;
      tag_vld_q  <= tag_vld_d;
      tag_id_q   <= tag_id_d;
    end
  end

  assign busy_o       = (state_q == RUN);
  assign done_o       = (state_q == DONE);
  assign im_a_valid_o = !empty_a;
  assign im_b_valid_o = !empty_b;

  im_fetch_scheduler_fifo #(
    .Width (ImAddrWidth),
    .Depth (ChanFifoDepth)
  ) u_fifo_a (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clr_i),
    .push_i  (push_a),
    .data_i  (mem_rdata_i),
    .pop_i   (im_a_ready_i),
    .data_o  (im_a_addr_o),
    .empty_o (empty_a),
    .count_o (cnt_a)
  );

  im_fetch_scheduler_fifo #(
    .Width (ImAddrWidth),
    .Depth (ChanFifoDepth)
  ) u_fifo_b (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clr_i),
    .push_i  (push_b),
    .data_i  (mem_rdata_i),
    .pop_i   (im_b_ready_i),
    .data_o  (im_b_addr_o),
    .empty_o (empty_b),
    .count_o (cnt_b)
  );

endmodule

// File: tb/tb_im_fetch_scheduler.sv
// Scoreboard bench for im_fetch_scheduler: randomized runs against a transaction-level model.
module tb_im_fetch_scheduler;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1, clr_i = 1'b0, start_i = 1'b0, port_b_en_i = 1'b0;
  logic [15:0] num_items_i = '0;
  logic [31:0] base_a_i = '0, base_b_i = '0, stride_i = '0;
  logic        busy_o, done_o, mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic [31:0] im_a_addr_o, im_b_addr_o;
  logic        im_a_valid_o, im_b_valid_o;
  logic        im_a_ready_i = 1'b0, im_b_ready_i = 1'b0;

  im_fetch_scheduler #(
    .MemAddrWidth  (32),
    .ImAddrWidth   (32),
    .CountWidth    (16),
    .ChanFifoDepth (2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .clr_i        (clr_i),
    .start_i      (start_i),
    .port_b_en_i  (port_b_en_i),
    .num_items_i  (num_items_i),
    .base_a_i     (base_a_i),
    .base_b_i     (base_b_i),
    .stride_i     (stride_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .im_a_addr_o  (im_a_addr_o),
    .im_a_valid_o (im_a_valid_o),
    .im_a_ready_i (im_a_ready_i),
    .im_b_addr_o  (im_b_addr_o),
    .im_b_valid_o (im_b_valid_o),
    .im_b_ready_i (im_b_ready_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Environment knobs
  int gnt_pct = 100, spur_pct = 0, gnt_low = 0;
  int rdy_pct_a = 100, rdy_pct_b = 100, rdy_low_a = 0, rdy_low_b = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;

  // Reference model state
  logic        run_m = 1'b0, zero_done = 1'b0, post_clr = 1'b0, b_en_m = 1'b0;
  int          tail = 0, num_m = 0, rr_m = 0, prev_chan = 0;
  int          iss[2], hs[2];
  logic        prev_req = 1'b0, prev_gnt = 1'b0;
  logic [31:0] addr_qa[$], addr_qb[$], data_qa[$], data_qb[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5EED_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder and ready generator
  always @(negedge clk) begin
    if (rst_i) begin
      pend         = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_gnt_i    = 1'b0;
    end else begin
      mem_rvalid_i = pend || ($urandom_range(99) < spur_pct);
      mem_rdata_i  = pend ? mem_word(pend_addr) : $urandom;
      if (gnt_low > 0) begin
        mem_gnt_i = 1'b0;
        gnt_low--;
      end else begin
        mem_gnt_i = ($urandom_range(99) < gnt_pct);
      end
      if (rdy_low_a > 0) begin
        im_a_ready_i = 1'b0;
        rdy_low_a--;
      end else begin
        im_a_ready_i = ($urandom_range(99) < rdy_pct_a);
      end
      if (rdy_low_b > 0) begin
        im_b_ready_i = 1'b0;
        rdy_low_b--;
      end else begin
        im_b_ready_i = ($urandom_range(99) < rdy_pct_b);
      end
      pend      = mem_req_o && mem_gnt_i;
      pend_addr = mem_addr_o;
    end
  end

  // Monitor: eligibility derived from items granted minus items handed over
  always @(negedge clk) begin : mon
    logic        e0, e1, hold, exp_req, exp_done, hs_evt;
    int          ch;
    logic [31:0] head;
    #1;
    if (rst_i) begin
      prev_req = 1'b0;
      prev_gnt = 1'b0;
      rr_m     = 0;
    end else begin
      exp_done = 1'b0;
      if (tail > 0) begin
        tail--;
        if (tail == 0) begin
          exp_done = 1'b1;
          run_m    = 1'b0;
        end
      end
      if (zero_done) begin
        exp_done  = 1'b1;
        zero_done = 1'b0;
      end
      check("busy", 32'(busy_o), 32'(run_m));
      check("done", 32'(done_o), 32'(exp_done));

      e0 = run_m && (iss[0] < num_m) && ((iss[0] - hs[0]) < 2);
      e1 = run_m && b_en_m && (iss[1] < num_m) && ((iss[1] - hs[1]) < 2);
      hold    = prev_req && !prev_gnt;
      exp_req = hold || e0 || e1;
      check("mem_req", 32'(mem_req_o), 32'(exp_req));
      ch = hold ? prev_chan : ((e0 && e1) ? rr_m : (e1 ? 1 : 0));
      if (mem_req_o && exp_req) begin
        head = (ch == 0) ? addr_qa[0] : addr_qb[0];
        check(hold ? "mem_addr_hold" : "mem_addr", mem_addr_o, head);
        if (mem_gnt_i) begin
          if (ch == 0) void'(addr_qa.pop_front());
          else         void'(addr_qb.pop_front());
          iss[ch]++;
          rr_m = 1 - ch;
        end
      end
      prev_req  = mem_req_o && exp_req;
      prev_gnt  = mem_gnt_i;
      prev_chan = ch;

      hs_evt = 1'b0;
      if (im_a_valid_o && im_a_ready_i) begin
        hs_evt = 1'b1;
        if (data_qa.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL im_a_unexpected: got 0x%0h, required no item (t=%0t)", im_a_addr_o, $time);
        end else begin
          check("im_a_addr", im_a_addr_o, data_qa.pop_front());
        end
        hs[0]++;
      end
      if (im_b_valid_o && im_b_ready_i) begin
        hs_evt = 1'b1;
        if (data_qb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL im_b_unexpected: got 0x%0h, required no item (t=%0t)", im_b_addr_o, $time);
        end else begin
          check("im_b_addr", im_b_addr_o, data_qb.pop_front());
        end
        hs[1]++;
      end
      if (hs_evt && run_m && tail == 0 && hs[0] == num_m && (!b_en_m || hs[1] == num_m))
        tail = 2;

      if (post_clr) begin
        check("clr_valid_a", 32'(im_a_valid_o), 32'd0);
        check("clr_valid_b", 32'(im_b_valid_o), 32'd0);
        post_clr = 1'b0;
      end
      if (clr_i) begin
        run_m = 1'b0; tail = 0; zero_done = 1'b0; post_clr = 1'b1;
        iss = '{0, 0}; hs = '{0, 0};
        prev_req = 1'b0;
        addr_qa.delete(); addr_qb.delete(); data_qa.delete(); data_qb.delete();
      end
    end
  end

  task automatic start_run(input int n, input logic ben, input logic [31:0] ba,
                           input logic [31:0] bb, input logic [31:0] st);
    logic [31:0] a;
    @(negedge clk);
    num_items_i = 16'(n);
    port_b_en_i = ben;
    base_a_i    = ba;
    base_b_i    = bb;
    stride_i    = st;
    start_i     = 1'b1;
    for (int i = 0; i < n; i++) begin
      a = ba + 32'(i) * st;
      addr_qa.push_back(a);
      data_qa.push_back(mem_word(a));
      if (ben) begin
        a = bb + 32'(i) * st;
        addr_qb.push_back(a);
        data_qb.push_back(mem_word(a));
      end
    end
    @(negedge clk);
    start_i = 1'b0;
    num_m   = n;
    b_en_m  = ben;
    iss     = '{0, 0};
    hs      = '{0, 0};
    tail    = 0;
    if (n > 0) run_m = 1'b1;
    else       zero_done = 1'b1;
    // Inputs after launch must not affect the run in flight
    num_items_i = 16'($urandom);
    base_a_i    = $urandom;
    base_b_i    = $urandom;
    stride_i    = $urandom;
    port_b_en_i = 1'($urandom);
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input logic misc);
    int c = 0;
    while ((run_m || tail != 0 || zero_done) && c < budget) begin
      @(negedge clk);
      c++;
      if (misc && run_m && $urandom_range(31) == 0) begin
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        c++;
      end
      if (misc && run_m && $urandom_range(99) == 0) begin
        do_clr();
        c += 2;
      end
    end
    if (run_m || tail != 0 || zero_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL run_timeout: run still open after %0d cycles, required completion", budget);
      do_clr();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy",   32'(busy_o),       32'd0);
    check("rst_done",   32'(done_o),       32'd0);
    check("rst_req",    32'(mem_req_o),    32'd0);
    check("rst_addr",   mem_addr_o,        32'd0);
    check("rst_valid_a", 32'(im_a_valid_o), 32'd0);
    check("rst_valid_b", 32'(im_b_valid_o), 32'd0);
    check("rst_im_a",   im_a_addr_o,       32'd0);
    check("rst_im_b",   im_b_addr_o,       32'd0);
    @(negedge clk);
    rst_i = 1'b0;

    // Alternating A/B grants from a fresh pointer
    start_run(3, 1'b1, 32'h0, 32'h100, 32'd1);
    wait_done(300, 1'b0);
    // Channel A alone
    start_run(4, 1'b0, 32'h10, 32'h0, 32'd1);
    wait_done(300, 1'b0);
    // Port A back-pressured while B keeps streaming
    rdy_low_a = 12;
    start_run(8, 1'b1, 32'h2000, 32'h3000, 32'd4);
    wait_done(500, 1'b0);
    // Grant withheld for three cycles mid-run
    start_run(6, 1'b1, 32'h500, 32'h900, 32'd2);
    repeat (3) @(negedge clk);
    gnt_low = 3;
    wait_done(500, 1'b0);
    // Empty run
    start_run(0, 1'b1, 32'h0, 32'h0, 32'd1);
    wait_done(20, 1'b0);
    // Address wrap at the top of the space
    start_run(5, 1'b1, 32'hFFFF_FFFE, 32'h8000_0000, 32'h4000_0000);
    wait_done(300, 1'b0);
    // Clear with a read in flight, then a clean restart
    start_run(8, 1'b1, 32'h40, 32'h80, 32'd1);
    repeat (2) @(negedge clk);
    do_clr();
    repeat (2) @(negedge clk);
    start_run(4, 1'b0, 32'h40, 32'h0, 32'd1);
    wait_done(300, 1'b0);

    spur_pct = 10;
    for (int r = 0; r < 60; r++) begin
      gnt_pct   = 30 + int'($urandom_range(70));
      rdy_pct_a = 20 + int'($urandom_range(80));
      rdy_pct_b = 20 + int'($urandom_range(80));
      start_run(int'($urandom_range(10)), 1'($urandom), $urandom, $urandom,
                ($urandom_range(3) == 0) ? $urandom : 32'($urandom_range(8)));
      wait_done(3000, 1'b1);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
